// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD request scheduler: FSM state encoding,
// default datapath width and a constant-evaluable ceil(log2) helper.
package gcd_pkg;

  // Default operand/result width of the shared Euclid engine.
  localparam int DW_DEFAULT = 8;

  // Scheduler states; the numeric encoding is visible on state_out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } gcd_state_t;

  // ceil(log2(value)), never less than 1 so that index/counter vectors
  // always have at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found when
// scanning upward from the slot after the last winner, wrapping around.
module gcd_rr_arbiter
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_valid
);

  // Scan NUM_REQ slots starting at last+1; the first hit wins and masks the rest.
  always_comb begin
    int          pos;
    logic [IW-1:0] slot;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    pos       = 0;
    slot      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      pos  = (int'(last) + off) % NUM_REQ;
      slot = pos[IW-1:0];
      if (!any_valid && req[slot]) begin
        grant[slot] = 1'b1;
        grant_idx   = slot;
        any_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Shares one start/done GCD engine between NUM_REQ requesters. Requests are
// taken round-robin one at a time; zero-operand requests are answered
// directly, everything else is sequenced through the engine under a
// watchdog that aborts a stalled engine and reports an error.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DW-1:0]     req_a,
  input  logic [NUM_REQ*DW-1:0]     req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DW-1:0]             rsp_gcd,
  output logic                      rsp_err,
  output logic                      eng_start,
  output logic [DW-1:0]             eng_a,
  output logic [DW-1:0]             eng_b,
  output logic                      eng_abort,
  input  logic                      eng_done,
  input  logic [DW-1:0]             eng_result,
  output logic [1:0]                state_out
);

  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  gcd_state_t           state_q;
  gcd_state_t           state_d;
  logic [IW-1:0]        last_q;
  logic [CW-1:0]        wd_cnt_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic                 any_valid;
  logic [DW-1:0]        sel_a;
  logic [DW-1:0]        sel_b;
  logic                 bypass;
  logic                 timeout_hit;

  gcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Operands of the requester that would win this cycle.
  assign sel_a       = req_a[grant_idx*DW +: DW];
  assign sel_b       = req_b[grant_idx*DW +: DW];
  // gcd(x,0) = x and gcd(0,0) = 0, so a zero operand never needs the engine.
  assign bypass      = (sel_a == '0) || (sel_b == '0);
  assign timeout_hit = (wd_cnt_q == WD_LAST);
  assign state_out   = state_q;

  // State register; reset drops any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes; a grant only exists in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = 1'b0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    case (state_q)
      IDLE: begin
        // Keep the grant quiet while reset is held so every output reads 0.
        req_ready = rst ? '0 : grant;
        if (any_valid) begin
          state_d = bypass ? RESP : START;
        end
      end
      START: begin
        eng_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        // A done arriving on the last watchdog cycle still counts as success.
        if (eng_done) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          eng_abort = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture at grant, watchdog counting and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= LAST_RST;
      wd_cnt_q <= '0;
      eng_a    <= '0;
      eng_b    <= '0;
      rsp_id   <= '0;
      rsp_gcd  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            last_q  <= grant_idx;
            rsp_id  <= grant_idx;
            eng_a   <= sel_a;
            eng_b   <= sel_b;
            rsp_err <= 1'b0;
            rsp_gcd <= bypass ? (sel_a | sel_b) : '0;
          end
        end
        START: begin
          wd_cnt_q <= '0;
        end
        WAIT: begin
          if (eng_done) begin
            rsp_gcd <= eng_result;
            rsp_err <= 1'b0;
          end else if (timeout_hit) begin
            rsp_gcd <= '0;
            rsp_err <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a transaction-level reference model,
// a simple latency-programmable GCD engine and a per-cycle compare process.
module tb_gcd_sched;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 255;
  localparam int IW      = 2;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_WAIT  = 2;
  localparam int P_RESP  = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*DW-1:0] req_a = '0;
  logic [NUM_REQ*DW-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IW-1:0]         rsp_id;
  logic [DW-1:0]         rsp_gcd;
  logic                  rsp_err;
  logic                  eng_start;
  logic [DW-1:0]         eng_a;
  logic [DW-1:0]         eng_b;
  logic                  eng_abort;
  logic                  eng_done = 1'b0;
  logic [DW-1:0]         eng_result = '0;
  logic [1:0]            state_out;

  gcd_sched #(.NUM_REQ(NUM_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_result(eng_result), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bounded wait expired, got no event, expected one (cycle %0d)", name, cyc);
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (v[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] gcd_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // ---------------- engine model ----------------
  int            eng_lat = 10;
  bit            eng_hang = 1'b0;
  bit            e_busy = 1'b0;
  int            e_cnt = 0;
  logic [DW-1:0] e_res = '0;
  logic [DW-1:0] e_seen_a = '0;
  logic [DW-1:0] e_seen_b = '0;
  int            e_starts = 0;
  int            e_start_cyc = -1;
  int            done_cyc = -1;

  always begin
    bit st, ab;
    @(negedge clk);
    st = eng_start;
    ab = eng_abort;
    if (eng_done) eng_done = 1'b0;
    if (ab) e_busy = 1'b0;
    if (st) begin
      e_busy = 1'b1; e_cnt = eng_lat; e_res = gcd_ref(eng_a, eng_b);
      e_seen_a = eng_a; e_seen_b = eng_b; e_starts++; e_start_cyc = cyc;
    end else if (e_busy && !eng_hang) begin
      e_cnt--;
      if (e_cnt == 0) begin
        eng_done = 1'b1; eng_result = e_res; e_busy = 1'b0; done_cyc = cyc;
      end
    end
  end

  // ---------------- reference model + compare ----------------
  int            m_phase = P_IDLE;
  int            m_last = NUM_REQ - 1;
  int            m_id = 0;
  int            m_k = 0;
  bit            m_first = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_gcd = '0;
  logic          m_err = 1'b0;
  int            abort_cnt = 0;
  int            abort_cyc = -1;
  int            grant_log[$];
  int            grant_cyc[$];
  int            rsp_id_log[$];
  int            rsp_gcd_log[$];
  int            rsp_err_log[$];
  int            rsp_cyc_log[$];
  int            rsp_first_cyc = -1;

  always begin
    int pick;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    #1;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_abort", eng_abort, 0);
      chk("rst_state", state_out, 0);
      chk("rst_eng_a", eng_a, 0);
      chk("rst_eng_b", eng_b, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_gcd", rsp_gcd, 0);
      chk("rst_rsp_err", rsp_err, 0);
      m_phase = P_IDLE;
      m_last  = NUM_REQ - 1;
    end else begin
      if (eng_abort) begin abort_cnt++; abort_cyc = cyc; end
      case (m_phase)
        P_IDLE: begin
          pick = rr_pick(req_valid, m_last);
          exp_rdy = '0;
          if (pick >= 0) exp_rdy[pick] = 1'b1;
          chk("idle_req_ready", req_ready, exp_rdy);
          chk("idle_rsp_valid", rsp_valid, 0);
          chk("idle_eng_start", eng_start, 0);
          chk("idle_eng_abort", eng_abort, 0);
          chk("idle_state", state_out, P_IDLE);
          if (pick >= 0) begin
            grant_log.push_back(pick);
            grant_cyc.push_back(cyc);
            m_last = pick; m_id = pick;
            m_a = req_a[pick*DW +: DW];
            m_b = req_b[pick*DW +: DW];
            if (m_a == 0 || m_b == 0) begin
              m_gcd = m_a | m_b; m_err = 1'b0; m_phase = P_RESP; m_first = 1'b1;
            end else begin
              m_phase = P_START;
            end
          end
        end
        P_START: begin
          chk("start_state", state_out, P_START);
          chk("start_eng_start", eng_start, 1);
          chk("start_eng_a", eng_a, m_a);
          chk("start_eng_b", eng_b, m_b);
          chk("start_req_ready", req_ready, 0);
          chk("start_rsp_valid", rsp_valid, 0);
          m_k = 0;
          m_phase = P_WAIT;
        end
        P_WAIT: begin
          m_k++;
          chk("wait_state", state_out, P_WAIT);
          chk("wait_eng_start", eng_start, 0);
          chk("wait_req_ready", req_ready, 0);
          chk("wait_rsp_valid", rsp_valid, 0);
          chk("wait_eng_abort", eng_abort, (m_k == TIMEOUT && !eng_done) ? 1 : 0);
          if (eng_done) begin
            m_gcd = eng_result; m_err = 1'b0; m_phase = P_RESP; m_first = 1'b1;
          end else if (m_k == TIMEOUT) begin
            m_gcd = '0; m_err = 1'b1; m_phase = P_RESP; m_first = 1'b1;
          end
        end
        default: begin
          chk("resp_state", state_out, P_RESP);
          chk("resp_rsp_valid", rsp_valid, 1);
          chk("resp_req_ready", req_ready, 0);
          chk("resp_eng_start", eng_start, 0);
          chk("resp_rsp_id", rsp_id, m_id);
          chk("resp_rsp_gcd", rsp_gcd, m_gcd);
          chk("resp_rsp_err", rsp_err, m_err);
          if (m_first) begin rsp_first_cyc = cyc; m_first = 1'b0; end
          if (rsp_ready) begin
            rsp_id_log.push_back(m_id);
            rsp_gcd_log.push_back(m_gcd);
            rsp_err_log.push_back(m_err);
            rsp_cyc_log.push_back(rsp_first_cyc);
            m_phase = P_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic send(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
    #1;
    for (int k = 0; k < 50 && !req_ready[i]; k++) begin @(negedge clk); #1; end
    if (!req_ready[i]) tmo("send_grant");
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 600 && m_phase != P_IDLE; k++) @(negedge clk);
    if (m_phase != P_IDLE) tmo(name);
  endtask

  task automatic wait_grants(input int n, input string name);
    for (int k = 0; k < 300 && grant_log.size() < n; k++) @(negedge clk);
    if (grant_log.size() < n) tmo(name);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int g0, r0, n, a0, dc;
    int exp_order[10];
    int gtab[4];
    exp_order = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
    gtab      = '{6, 3, 7, 25};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_state_out", state_out, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    rst = 1'b0;

    // Single engine request: requester 1, gcd(15,24)=3 after 10 cycles
    eng_lat = 10;
    send(1, 8'd15, 8'd24);
    wait_idle("t1_idle");
    chk("t1_grant_id", grant_log[$], 1);
    chk("t1_eng_a", e_seen_a, 15);
    chk("t1_eng_b", e_seen_b, 24);
    chk("t1_start_at_T1", e_start_cyc, grant_cyc[$] + 1);
    chk("t1_rsp_id", rsp_id_log[$], 1);
    chk("t1_rsp_gcd", rsp_gcd_log[$], 3);
    chk("t1_rsp_err", rsp_err_log[$], 0);
    chk("t1_rsp_at_done1", rsp_cyc_log[$], done_cyc + 1);

    // Zero bypass: no engine use, answer at T+1
    n = e_starts;
    send(2, 8'd0, 8'd24);
    wait_idle("t2_idle");
    chk("t2_rsp_gcd", rsp_gcd_log[$], 24);
    chk("t2_rsp_id", rsp_id_log[$], 2);
    chk("t2_rsp_at_T1", rsp_cyc_log[$], grant_cyc[$] + 1);
    send(2, 8'd0, 8'd0);
    wait_idle("t2b_idle");
    chk("t2b_rsp_gcd", rsp_gcd_log[$], 0);
    send(3, 8'd35, 8'd0);
    wait_idle("t2c_idle");
    chk("t2c_rsp_gcd", rsp_gcd_log[$], 35);
    chk("t2_no_eng_start", e_starts, n);

    // Round robin with all requesters valid from reset, then requester 2 drops
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    eng_lat = 2;
    g0 = grant_log.size();
    r0 = rsp_id_log.size();
    @(negedge clk);
    set_ops(0, 8'd12, 8'd18);
    set_ops(1, 8'd15, 8'd24);
    set_ops(2, 8'd49, 8'd14);
    set_ops(3, 8'd100, 8'd75);
    req_valid = 4'hF;
    wait_grants(g0 + 6, "t3_six_grants");
    req_valid[2] = 1'b0;
    wait_grants(g0 + 10, "t3_ten_grants");
    req_valid = '0;
    wait_idle("t3_idle");
    for (int k = 0; k < 10; k++) begin
      if (g0 + k < grant_log.size()) chk("t3_grant_order", grant_log[g0 + k], exp_order[k]);
      else tmo("t3_grant_missing");
      if (r0 + k < rsp_id_log.size())
        chk("t3_rsp_gcd", rsp_gcd_log[r0 + k], gtab[rsp_id_log[r0 + k]]);
      else tmo("t3_rsp_missing");
    end

    // Engine hang: watchdog abort 255 cycles into WAIT, then normal service
    eng_hang = 1'b1;
    a0 = abort_cnt;
    send(1, 8'd20, 8'd8);
    wait_idle("t4_idle");
    chk("t4_abort_count", abort_cnt, a0 + 1);
    chk("t4_abort_delay", abort_cyc - e_start_cyc, 255);
    chk("t4_rsp_err", rsp_err_log[$], 1);
    chk("t4_rsp_gcd", rsp_gcd_log[$], 0);
    chk("t4_rsp_id", rsp_id_log[$], 1);
    eng_hang = 1'b0;
    eng_lat = 4;
    send(2, 8'd9, 8'd7);
    wait_idle("t4b_idle");
    chk("t4b_rsp_gcd", rsp_gcd_log[$], 1);
    chk("t4b_rsp_err", rsp_err_log[$], 0);
    chk("t4b_abort_count", abort_cnt, a0 + 1);

    // Backpressure: response held 20 cycles, no grants or engine starts
    rsp_ready = 1'b0;
    eng_lat = 3;
    n = e_starts;
    send(0, 8'd8, 8'd12);
    for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
    if (!rsp_valid) tmo("t5_rsp_valid");
    set_ops(1, 8'd21, 8'd14);
    set_ops(2, 8'd49, 8'd14);
    set_ops(3, 8'd100, 8'd75);
    req_valid = 4'b1110;
    repeat (20) @(negedge clk);
    #1;
    chk("t5_req_ready", req_ready, 0);
    chk("t5_rsp_gcd", rsp_gcd, 4);
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_eng_starts", e_starts, n + 1);
    g0 = grant_log.size();
    rsp_ready = 1'b1;
    wait_grants(g0 + 1, "t5_next_grant");
    req_valid = '0;
    wait_idle("t5_idle");
    if (g0 < grant_log.size()) chk("t5_next_rr", grant_log[g0], 1);
    chk("t5b_rsp_gcd", rsp_gcd_log[$], 7);

    // Reset during WAIT; late eng_done ignored; requester 0 first afterwards
    eng_lat = 20;
    send(0, 8'd27, 8'd81);
    for (int k = 0; k < 20 && state_out != 2'd2; k++) @(negedge clk);
    if (state_out != 2'd2) tmo("t6_wait_state");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_state", state_out, 0);
    chk("t6_rst_eng_a", eng_a, 0);
    chk("t6_rst_eng_b", eng_b, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dc = done_cyc;
    for (int k = 0; k < 40 && done_cyc == dc; k++) @(negedge clk);
    if (done_cyc == dc) tmo("t6_late_done");
    repeat (3) @(negedge clk);
    chk("t6_after_late_done_state", state_out, 0);
    g0 = grant_log.size();
    set_ops(0, 8'd12, 8'd18);
    set_ops(3, 8'd100, 8'd75);
    req_valid = 4'b1001;
    wait_grants(g0 + 1, "t6_grant");
    req_valid = '0;
    wait_idle("t6_idle");
    if (g0 < grant_log.size()) chk("t6_first_priority", grant_log[g0], 0);
    chk("t6_rsp_gcd", rsp_gcd_log[$], 6);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
